// File: rtl/lcd_pkg.sv
// Shared FSM/strobe types, power-on init tables and a timing helper for the HD44780 controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    INIT_NIB,
    INIT_WAIT,
    CMD_HI,
    CMD_LO,
    POST_WAIT,
    IDLE
  } lcd_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SETUP,
    TX_PULSE,
    TX_HOLD
  } tx_phase_t;

  typedef enum logic [1:0] {
    W_INIT1,
    W_INIT2,
    W_CMD
  } wait_sel_t;

  // 8-bit-mode wake-up nibbles, then the switch to 4-bit mode, each with its settle time
  localparam logic [3:0] INIT_NIBS  [4] = '{4'h3, 4'h3, 4'h3, 4'h2};
  localparam wait_sel_t  INIT_WAITS [4] = '{W_INIT1, W_INIT2, W_CMD, W_CMD};

  // function set 4-bit/2-line, display on, clear, entry mode increment
  localparam logic [7:0] INIT_BYTES [4] = '{8'h28, 8'h0C, 8'h01, 8'h06};

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  function automatic int tmax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_hd44780_ctrl_if.sv
// Byte-write handshake from the control plane into the LCD controller.
interface lcd_hd44780_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_rs;

  modport master (output in_valid, output in_data, output in_rs, input in_ready);
  modport slave  (input in_valid, input in_data, input in_rs, output in_ready);
endinterface

// File: rtl/lcd_nibble_tx.sv
// One LCD nibble strobe: SETUP (T_AS) / PULSE e=1 (T_EPW) / HOLD (T_NIB); registered outputs.
// done is combinational in the last HOLD cycle; a start on that cycle chains the next nibble with no gap.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int T_AS  = 5,
  parameter int T_EPW = 30,
  parameter int T_NIB = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] nibble,
  input  logic       rs,
  output logic       done,
  output logic       idle,
  output logic [3:0] lcd_db,
  output logic       lcd_e,
  output logic       lcd_rs
);

  localparam int CW = $clog2(tmax(tmax(T_AS, T_EPW), T_NIB) + 1);

  tx_phase_t     phase, phase_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    db_n;
  logic          e_n, rs_n;
  logic          last;

  assign last = (cnt == CW'(1));
  assign idle = (phase == TX_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= TX_IDLE;
      cnt    <= '0;
      lcd_db <= 4'h0;
      lcd_e  <= 1'b0;
      lcd_rs <= 1'b0;
    end else begin
      phase  <= phase_n;
      cnt    <= cnt_n;
      lcd_db <= db_n;
      lcd_e  <= e_n;
      lcd_rs <= rs_n;
    end
  end

  always_comb begin
    phase_n = phase;
    cnt_n   = cnt;
    db_n    = lcd_db;
    e_n     = lcd_e;
    rs_n    = lcd_rs;
    done    = 1'b0;
    case (phase)
      TX_IDLE: begin
        if (start) begin
          phase_n = TX_SETUP;
          cnt_n   = CW'(T_AS);
          db_n    = nibble;
          rs_n    = rs;
          e_n     = 1'b0;
        end
      end
      TX_SETUP: begin
        cnt_n = cnt - CW'(1);
        if (last) begin
          phase_n = TX_PULSE;
          cnt_n   = CW'(T_EPW);
          e_n     = 1'b1;
        end
      end
      TX_PULSE: begin
        cnt_n = cnt - CW'(1);
        if (last) begin
          phase_n = TX_HOLD;
          cnt_n   = CW'(T_NIB);
          e_n     = 1'b0;
        end
      end
      TX_HOLD: begin
        cnt_n = cnt - CW'(1);
        if (last) begin
          done = 1'b1;
          if (start) begin
            phase_n = TX_SETUP;
            cnt_n   = CW'(T_AS);
            db_n    = nibble;
            rs_n    = rs;
          end else begin
            phase_n = TX_IDLE;
          end
        end
      end
      default: phase_n = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 4-bit controller: autonomous power-on init, then one byte per handshake as two nibble strobes.
// Accept-to-first-e is 1+T_AS; in_ready is low from the cycle after acceptance until the post-byte wait ends.
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int T_PWRUP = 1875000,
  parameter int T_INIT1 = 512500,
  parameter int T_INIT2 = 12500,
  parameter int T_AS    = 5,
  parameter int T_EPW   = 30,
  parameter int T_NIB   = 125,
  parameter int T_CMD   = 5000,
  parameter int T_CLR   = 205000
) (
  input  logic               CLK,
  input  logic               RST_N,
  lcd_hd44780_ctrl_if.slave  bus,
  output logic               init_done,
  output logic               busy,
  output logic [3:0]         lcd_db,
  output logic               lcd_e,
  output logic               lcd_rs,
  output logic               lcd_rw
);

  localparam int T_MAX = tmax(tmax(tmax(T_PWRUP, T_INIT1), tmax(T_INIT2, T_AS)),
                              tmax(tmax(T_EPW, T_NIB), tmax(T_CMD, T_CLR)));
  localparam int CW    = $clog2(T_MAX + 1);

  lcd_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n, init_wait;
  logic [1:0]    idx, idx_n, idx_nx;
  logic [7:0]    data_q, data_n, rom_byte;
  logic          rs_q, rs_n;
  logic          init_done_q, init_done_n;
  logic          wait_end, post_long;
  logic          tx_start, tx_rs, tx_done, tx_idle;
  logic [3:0]    tx_nib;

  assign bus.in_ready = (state == IDLE);
  assign busy         = (state != IDLE);
  assign init_done    = init_done_q;
  assign lcd_rw       = 1'b0;

  assign wait_end  = (cnt == CW'(1));
  assign idx_nx    = idx + 2'd1;
  assign rom_byte  = INIT_BYTES[(state == INIT_WAIT) ? 2'd0 : idx_nx];
  assign post_long = !rs_q && ((data_q == CMD_CLEAR) || (data_q == CMD_HOME));

  always_comb begin
    case (INIT_WAITS[idx])
      W_INIT1: init_wait = CW'(T_INIT1);
      W_INIT2: init_wait = CW'(T_INIT2);
      default: init_wait = CW'(T_CMD);
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= PWRUP;
      cnt         <= CW'(T_PWRUP);
      idx         <= 2'd0;
      data_q      <= 8'h00;
      rs_q        <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      data_q      <= data_n;
      rs_q        <= rs_n;
      init_done_q <= init_done_n;
    end
  end

  // Wait phases end on the same edge that launches the next nibble, so init has no idle gaps.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    data_n      = data_q;
    rs_n        = rs_q;
    init_done_n = init_done_q;
    tx_start    = 1'b0;
    tx_nib      = data_q[7:4];
    tx_rs       = rs_q;
    case (state)
      PWRUP: begin
        cnt_n = cnt - CW'(1);
        if (wait_end) begin
          state_n  = INIT_NIB;
          idx_n    = 2'd0;
          tx_start = 1'b1;
          tx_nib   = INIT_NIBS[0];
          tx_rs    = 1'b0;
        end
      end
      INIT_NIB: begin
        if (tx_done) begin
          state_n = INIT_WAIT;
          cnt_n   = init_wait;
        end
      end
      INIT_WAIT: begin
        cnt_n = cnt - CW'(1);
        if (wait_end) begin
          tx_start = 1'b1;
          tx_rs    = 1'b0;
          if (idx == 2'd3) begin
            state_n = CMD_HI;
            idx_n   = 2'd0;
            data_n  = rom_byte;
            rs_n    = 1'b0;
            tx_nib  = rom_byte[7:4];
          end else begin
            state_n = INIT_NIB;
            idx_n   = idx_nx;
            tx_nib  = INIT_NIBS[idx_nx];
          end
        end
      end
      CMD_HI: begin
        if (tx_done) begin
          state_n  = CMD_LO;
          tx_start = 1'b1;
          tx_nib   = data_q[3:0];
        end else if (tx_idle) begin
          tx_start = 1'b1;
        end
      end
      CMD_LO: begin
        if (tx_done) begin
          state_n = POST_WAIT;
          cnt_n   = post_long ? CW'(T_CLR) : CW'(T_CMD);
        end
      end
      POST_WAIT: begin
        cnt_n = cnt - CW'(1);
        if (wait_end) begin
          if (init_done_q) begin
            state_n = IDLE;
          end else if (idx == 2'd3) begin
            state_n     = IDLE;
            init_done_n = 1'b1;
          end else begin
            state_n  = CMD_HI;
            idx_n    = idx_nx;
            data_n   = rom_byte;
            rs_n     = 1'b0;
            tx_start = 1'b1;
            tx_nib   = rom_byte[7:4];
            tx_rs    = 1'b0;
          end
        end
      end
      IDLE: begin
        if (bus.in_valid) begin
          state_n = CMD_HI;
          data_n  = bus.in_data;
          rs_n    = bus.in_rs;
        end
      end
      default: state_n = PWRUP;
    endcase
  end

  lcd_nibble_tx #(
    .T_AS  (T_AS),
    .T_EPW (T_EPW),
    .T_NIB (T_NIB)
  ) u_tx (
    .clk    (CLK),
    .rst_n  (RST_N),
    .start  (tx_start),
    .nibble (tx_nib),
    .rs     (tx_rs),
    .done   (tx_done),
    .idle   (tx_idle),
    .lcd_db (lcd_db),
    .lcd_e  (lcd_e),
    .lcd_rs (lcd_rs)
  );

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed bench for lcd_hd44780_ctrl with short timing parameters.
module tb_lcd_hd44780_ctrl;

  localparam int T_AS  = 2;
  localparam int T_EPW = 3;
  localparam int T_NIB = 4;
  localparam int LAT_E = 1 + T_AS;
  localparam int NIB_GAP = T_AS + T_EPW + T_NIB;
  localparam int INIT_DONE_CYC = 231;

  typedef struct {
    logic [3:0] nib;
    logic       rs;
    int         cyc;
  } nib_rec_t;

  typedef struct {
    logic [7:0] dat;
    logic       rs;
    int         lat;
  } byte_vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init_done, busy, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_db;

  int errors = 0;
  int checks = 0;
  int cyc;

  nib_rec_t  seen [$];
  nib_rec_t  init_exp [12];
  byte_vec_t vecs [6];
  int         init_cyc [12] = '{22, 46, 63, 82, 101, 110, 129, 138, 157, 166, 205, 214};
  logic [3:0] init_nib [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};

  logic       e_prev = 1'b0;
  logic [3:0] db_hold = 4'h0;
  logic       rs_hold = 1'b0;
  logic       unstable = 1'b0;
  logic       rw_bad = 1'b0;
  int         width = 0;

  lcd_hd44780_ctrl_if bus ();

  lcd_hd44780_ctrl #(
    .T_PWRUP (20),
    .T_INIT1 (15),
    .T_INIT2 (8),
    .T_AS    (T_AS),
    .T_EPW   (T_EPW),
    .T_NIB   (T_NIB),
    .T_CMD   (10),
    .T_CLR   (30)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .bus       (bus),
    .init_done (init_done),
    .busy      (busy),
    .lcd_db    (lcd_db),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Strobe monitor: records each nibble on e rise, checks pulse width and db/rs stability while e is high.
  always @(negedge clk) begin
    nib_rec_t r;
    if (lcd_rw !== 1'b0) rw_bad = 1'b1;
    if (!rst_n) begin
      e_prev = 1'b0;
      width  = 0;
    end else begin
      if (lcd_e && !e_prev) begin
        r.nib = lcd_db;
        r.rs  = lcd_rs;
        r.cyc = cyc;
        seen.push_back(r);
        db_hold  = lcd_db;
        rs_hold  = lcd_rs;
        width    = 1;
        unstable = 1'b0;
      end else if (lcd_e) begin
        width++;
        if (lcd_db !== db_hold || lcd_rs !== rs_hold) unstable = 1'b1;
      end else if (e_prev) begin
        check("e_width", width, T_EPW);
        check("db_rs_stable_while_e", unstable, 0);
      end
      e_prev = lcd_e;
    end
  end

  task automatic check_init();
    for (int i = 0; i < 400 && !bus.in_ready; i++) @(negedge clk);
    check("init_done_cycle", cyc, INIT_DONE_CYC);
    check("init_done_busy", {init_done, busy}, 2'b10);
    check("init_nib_count", seen.size(), 12);
    for (int i = 0; i < 12 && i < seen.size(); i++) begin
      check($sformatf("init%0d_rs_nib", i), {seen[i].rs, seen[i].nib}, {init_exp[i].rs, init_exp[i].nib});
      check($sformatf("init%0d_e_cycle", i), seen[i].cyc, init_exp[i].cyc);
    end
    seen.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic r, output int t0, output int lat);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_rs    = r;
    @(negedge clk);
    t0 = cyc;
    bus.in_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (bus.in_ready) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_xfer(input string tag, input logic [7:0] d, input logic r,
                            input int t0, input int lat, input int lat_exp);
    check({tag, "_ready_latency"}, lat, lat_exp);
    check({tag, "_nib_count"}, seen.size(), 2);
    if (seen.size() >= 2) begin
      check({tag, "_hi"}, {seen[0].rs, seen[0].nib}, {r, d[7:4]});
      check({tag, "_lo"}, {seen[1].rs, seen[1].nib}, {r, d[3:0]});
      check({tag, "_first_e_latency"}, seen[0].cyc - t0, LAT_E);
      check({tag, "_nibble_gap"}, seen[1].cyc - seen[0].cyc, NIB_GAP);
    end
    seen.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded 100000 ns, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, lat;
    for (int i = 0; i < 12; i++) begin
      init_exp[i].nib = init_nib[i];
      init_exp[i].rs  = 1'b0;
      init_exp[i].cyc = init_cyc[i];
    end
    vecs[0] = '{8'h41, 1'b1, 29};
    vecs[1] = '{8'h01, 1'b0, 49};
    vecs[2] = '{8'h02, 1'b0, 49};
    vecs[3] = '{8'h03, 1'b0, 29};
    vecs[4] = '{8'h01, 1'b1, 29};
    vecs[5] = '{8'h00, 1'b0, 29};

    // valid held with 0x55 from reset: must be ignored until init completes, then taken exactly once
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    bus.in_rs    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {lcd_db, lcd_e, lcd_rs, lcd_rw, bus.in_ready, init_done, busy}, 10'h001);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("pre_init_ready_low", {bus.in_ready, init_done, busy}, 3'b001);
    check_init();

    @(negedge clk);
    t0 = cyc;
    check("held_valid_accept_cycle", t0, INIT_DONE_CYC + 1);
    check("held_valid_ready_drop", {bus.in_ready, busy}, 2'b01);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (bus.in_ready) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check_xfer("held55", 8'h55, 1'b1, t0, lat, 29);
    repeat (3) @(negedge clk);
    check("no_second_accept", {bus.in_ready, busy, 8'(seen.size())}, {2'b10, 8'd0});

    for (int v = 0; v < 6; v++) begin
      send(vecs[v].dat, vecs[v].rs, t0, lat);
      check_xfer($sformatf("vec%0d", v), vecs[v].dat, vecs[v].rs, t0, lat, vecs[v].lat);
    end

    // reset in the middle of a data pulse
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h41;
    bus.in_rs    = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (LAT_E + 1) @(negedge clk);
    check("pulse_before_reset", {lcd_e, lcd_rs, lcd_db}, {1'b1, 1'b1, 4'h4});
    #1 rst_n = 1'b0;
    #1 check("mid_strobe_reset", {lcd_db, lcd_e, lcd_rs, lcd_rw, bus.in_ready, init_done, busy}, 10'h001);
    repeat (2) @(negedge clk);
    seen.delete();
    rst_n = 1'b1;
    check_init();

    check("lcd_rw_never_high", rw_bad, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_ctrl.md
Name: lcd_hd44780_ctrl

Overview:
Character-LCD controller that drives the ML605 16x2 HD44780-compatible display through the 4-bit pin group (lcd_db, lcd_e, lcd_rs, lcd_rw) at the board top level. It runs the power-on initialisation sequence autonomously. It then accepts command and data bytes from the control plane over a valid/ready handshake and serialises each byte as two nibble strobes with HD44780 timing. It sits directly upstream of the LCD pins and replaces ad-hoc LCD logic inside the top-level wrapper.

Parameters:
T_PWRUP, 1875000, cycles to wait after reset before first init nibble (15 ms at 125 MHz)
T_INIT1, 512500, wait after first 0x3 init nibble (4.1 ms)
T_INIT2, 12500, wait after second 0x3 init nibble (100 us)
T_AS, 5, cycles db/rs are stable before lcd_e rises
T_EPW, 30, lcd_e high width in cycles
T_NIB, 125, lcd_e low hold after each nibble before the next phase
T_CMD, 5000, post-byte wait for ordinary commands and data (40 us)
T_CLR, 205000, post-byte wait for clear (0x01) and home (0x02) commands (1.64 ms)

Ports:
CLK  in  1  controller clock
RST_N  in  1  asynchronous active-low reset
in_valid  in  1  byte offered
in_ready  out  1  controller can accept a byte this cycle
in_data  in  8  byte to write
in_rs  in  1  0 = command, 1 = character data
init_done  out  1  initialisation sequence complete
busy  out  1  high whenever the controller is not in IDLE
lcd_db  out  4  LCD data nibble
lcd_e  out  1  LCD enable strobe
lcd_rs  out  1  LCD register select
lcd_rw  out  1  LCD read/write; tied 0 (write-only)

Behaviour:
- Reset is asynchronous and active-low on RST_N. Clock is CLK. All state registers clear asynchronously.
- Reset values: lcd_db=0, lcd_e=0, lcd_rs=0, lcd_rw=0, in_ready=0, init_done=0, busy=1. The FSM enters PWRUP.
- All LCD outputs are registered. lcd_rw is constant 0.
- A phase of N cycles holds its outputs for exactly N rising edges. Every timing parameter must be >= 1.
- One shared down-counter times all phases. Its width is clog2(max parameter + 1). A phase ends when the counter reaches 1, and the next phase loads the counter on the same edge.
- Nibble strobe, in order:
  - SETUP for T_AS cycles: drive db and rs, e=0.
  - PULSE for T_EPW cycles: e=1, db and rs held.
  - HOLD for T_NIB cycles: e=0, db and rs held.
- FSM states: PWRUP, INIT_NIB, INIT_WAIT, CMD_HI, CMD_LO, POST_WAIT, IDLE.
- Init flow:
  - PWRUP waits T_PWRUP.
  - Init nibbles are sent with rs=0 in this order: 0x3 (then wait T_INIT1), 0x3 (T_INIT2), 0x3 (T_CMD), 0x2 (T_CMD).
  - Init bytes are then sent with rs=0, each as a high nibble then a low nibble: 0x28, 0x0C, 0x01, 0x06. Each is followed by its post-byte wait.
  - After the final wait: init_done=1 (sticky until reset), enter IDLE.
- IDLE: in_ready=1 and busy=0. A transfer is accepted on any edge where in_valid && in_ready.
  - in_data and in_rs are captured on that edge.
  - in_ready drops on the following cycle; busy rises on the following cycle.
- Byte transfer: CMD_HI sends in_data[7:4]; CMD_LO sends in_data[3:0]. lcd_rs equals the captured in_rs throughout both nibbles.
- POST_WAIT duration: T_CLR if rs=0 and the byte is 0x01 or 0x02; otherwise T_CMD. Then return to IDLE.
- Latency:
  - From acceptance to the first lcd_e rise: 1 + T_AS cycles.
  - Accept to in_ready high again: 2*(T_AS+T_EPW+T_NIB) + wait + 1 cycles, where wait is T_CMD or T_CLR.
- in_valid asserted before init_done is ignored: in_ready is 0, nothing is captured, and no error is raised.
- RST_N asserted mid-strobe drops lcd_e immediately, with no glitch extension. The full init sequence restarts after reset.
- in_valid deasserting while in_ready=0 has no effect.

Decomposition:
- Package lcd_pkg:
  - FSM state enum.
  - Init nibble list {3,3,3,2} with matching wait selectors.
  - Init byte ROM {0x28,0x0C,0x01,0x06}.
  - Constants CMD_CLEAR=0x01 and CMD_HOME=0x02.
- Sub-module lcd_nibble_tx:
  - Owns the SETUP/PULSE/HOLD sequence and its counter.
  - Inputs: start, nibble, rs.
  - Outputs: done pulse, plus db/e/rs.
- The top FSM sequences nibbles and waits.

Test Plan:
Bench parameters: T_PWRUP=20, T_INIT1=15, T_INIT2=8, T_AS=2, T_EPW=3, T_NIB=4, T_CMD=10, T_CLR=30.
1. Release reset -> first lcd_e rise at cycle 20+2 after reset release. The nibble sequence captured on e rising is 3,3,3,2,2,8,0,C,0,1,0,6, all with rs=0. init_done rises after the final T_CMD wait.
2. After init, offer in_data=0x41, in_rs=1 -> captured nibbles 4 then 1 with rs=1. e high exactly 3 cycles per nibble. in_ready returns exactly 2*9+10+1=29 cycles after acceptance.
3. Offer in_data=0x01, in_rs=0 -> post-byte wait is 30 cycles. Ready returns 49 cycles after acceptance. Repeat with 0x02 (same 49) and 0x03 (29).
4. Hold in_valid=1 with data 0x55 from reset -> no capture before init_done. Exactly one transfer of 0x55 immediately after init. Back-to-back valid is accepted only when in_ready=1.
5. Assert RST_N low during PULSE of a data nibble -> lcd_e, lcd_db and lcd_rs go 0 asynchronously and init_done=0. After release the full init sequence repeats.
6. Throughout all tests -> lcd_rw stays 0, and db/rs never change while lcd_e=1.
